// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle instruction sequencer in front of the 16-bit accumulator ALU.
// Fetches over a req/ack memory port, owns acc/operand/pc, executes store, jump and halt.
// Optional build macro CPU_CTRL_STEP_EN adds the stepGo port and a PAUSE state that
// holds the core between instructions until stepGo is seen high.
//
// state   | meaning
// FETCH   | read mem[pc] into the instruction register, pc advances on completion
// DECODE  | dispatch on the opcode
// OPERAND | read mem[addr] into the operand register (ADD/LOAD)
// EXECUTE | drive aluCode; acc takes aluRes, or negFlag takes aluNeg for TEST
// STORE   | write acc to mem[addr]
// BRANCH  | JMP, or JN when negFlag is set
// HALT    | terminal until reset
// PAUSE   | single-step hold, only with CPU_CTRL_STEP_EN
module cpu_ctrl #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWData,
  input  logic [15:0]       memRData,
  input  logic              memRdy,
  output logic [3:0]        aluCode,
  output logic [15:0]       aluA,
  output logic [15:0]       aluB,
  input  logic [15:0]       aluRes,
  input  logic              aluNeg,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef CPU_CTRL_STEP_EN
  ,
  input  logic              stepGo
`endif
);

  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b0110;
  localparam logic [3:0] OP_TEST  = 4'b0111;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_JMP   = 4'b1001;
  localparam logic [3:0] OP_JN    = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1111;
  localparam logic [3:0] ALU_PASS = 4'b0101;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_OPERAND = 3'd2,
    S_EXECUTE = 3'd3,
    S_STORE   = 3'd4,
    S_BRANCH  = 3'd5,
    S_HALT    = 3'd6
`ifdef CPU_CTRL_STEP_EN
    ,
    S_PAUSE   = 3'd7
`endif
  } state_t;

  // Where every completed instruction goes next.
`ifdef CPU_CTRL_STEP_EN
  localparam state_t S_DONE = S_PAUSE;
`else
  localparam state_t S_DONE = S_FETCH;
`endif

  state_t              state_q, state_d;
  logic [15:0]         ir_q;
  logic [15:0]         acc_q;
  logic [15:0]         opnd_q;
  logic                neg_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                xfer_done;
  logic                req_d, we_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [15:0]         wdata_d;
  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   ir_addr;

  assign opcode    = ir_q[15:12];
  assign ir_addr   = ADDR_W'(ir_q[11:0]);
  // memRdy only counts while a request is actually outstanding.
  assign xfer_done = memReq & memRdy;

  assign aluA    = acc_q;
  assign aluB    = opnd_q;
  assign pc      = pc_q;
  assign halted  = (state_q == S_HALT);
  // PASS A outside EXECUTE keeps the ALU flag quiet.
  assign aluCode = (state_q == S_EXECUTE) ? opcode : ALU_PASS;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next state, next pc and next values of the registered memory port.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        if (xfer_done) begin
          state_d = S_DECODE;
          pc_d    = pc_q + ADDR_W'(1);
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_LOAD:                       state_d = S_OPERAND;
          4'b0000, 4'b0001, 4'b0010, 4'b0011,
          4'b0101, OP_TEST:                      state_d = S_EXECUTE;
          OP_STORE:                              state_d = S_STORE;
          OP_JMP, OP_JN:                         state_d = S_BRANCH;
          OP_HALT:                               state_d = S_HALT;
          default:                               state_d = S_DONE;
        endcase
      end
      S_OPERAND: if (xfer_done) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_DONE;
      S_STORE:   if (xfer_done) state_d = S_DONE;
      S_BRANCH: begin
        if (opcode == OP_JMP || neg_q) pc_d = ir_addr;
        state_d = S_DONE;
      end
      S_HALT:    state_d = S_HALT;
`ifdef CPU_CTRL_STEP_EN
      S_PAUSE:   if (stepGo) state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase

    // A completed transfer always forces one idle cycle on memReq,
    // even when the next state issues a new request (STORE -> FETCH).
    req_d   = ((state_d == S_FETCH) || (state_d == S_OPERAND) || (state_d == S_STORE))
              && !xfer_done;
    addr_d  = memAddr;
    if (req_d) addr_d = (state_d == S_FETCH) ? pc_d : ir_addr;
    we_d    = req_d && (state_d == S_STORE);
    wdata_d = we_d ? acc_q : memWData;
  end

  // Registered memory port; held stable for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= RESET_PC;
      memWData <= 16'h0000;
    end else begin
      memReq   <= req_d;
      memWe    <= we_d;
      memAddr  <= addr_d;
      memWData <= wdata_d;
    end
  end

  // Datapath registers: instruction, operand, accumulator, flag and pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q   <= 16'h0000;
      opnd_q <= 16'h0000;
      acc_q  <= 16'h0000;
      neg_q  <= 1'b0;
      pc_q   <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (state_q == S_FETCH && xfer_done)   ir_q   <= memRData;
      if (state_q == S_OPERAND && xfer_done) opnd_q <= memRData;
      if (state_q == S_EXECUTE) begin
        if (opcode == OP_TEST) neg_q <= aluNeg;
        else                   acc_q <= aluRes;
      end
    end
  end

endmodule
